adc_frame_builder: RTL and testbench

ADC_FRAME_BUILDER -- requirements
Module: adc_frame_builder

---
 rtl/adc_frame_builder_pkg.sv | 35 +++
 rtl/adc_frame_builder_frame_fifo.sv | 70 +++++++
 rtl/adc_frame_builder.sv | 215 +++++++++++++++++++++
 tb/tb_adc_frame_builder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_frame_builder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_frame_builder_pkg
// Description : Shared constants, state encoding and trailer helper for the
//               ADC frame builder and its output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_frame_builder_pkg;

    // Frame framing constants
    localparam logic [15:0] HEADER_WORD = 16'hADC5;
    localparam logic [3:0]  TRAILER_TAG = 4'hE;

    // Output FIFO geometry (DEPTH must equal 2**AW)
    localparam int FIFO_DEPTH = 32;
    localparam int FIFO_AW    = 5;
    localparam int DATA_W     = 16;

    // Frame builder state encoding
    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_HEADER   = 3'd1;
    localparam state_t ST_EVENT_ID = 3'd2;
    localparam state_t ST_SAMPLES  = 3'd3;
    localparam state_t ST_TRAILER  = 3'd4;

    // Trailer layout: tag, sticky overflow flag, three zero bits, sample count
    function automatic logic [15:0] trailerWord(input logic ovf, input logic [7:0] cnt);
        return {TRAILER_TAG, ovf, 3'b000, cnt};
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_frame_builder_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : frame_fifo
// Description : Synchronous single-clock FIFO with full/empty flags and a
//               registered (non fall-through) read port. Writes while full
//               and reads while empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_fifo
    import adc_frame_builder_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wrEn,
    input  logic [WIDTH-1:0] i_wrData,
    input  logic             i_rdEn,
    output logic [WIDTH-1:0] o_rdData,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic [WIDTH-1:0] r_rdData;
    logic             w_full;
    logic             w_empty;
    logic             w_doWr;
    logic             w_doRd;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_doWr  = i_wrEn && !w_full;
    assign w_doRd  = i_rdEn && !w_empty;

    // Storage array; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (w_doWr) begin
            r_mem[r_wrPtr[AW-1:0]] <= i_wrData;
        end
    end

    // Pointer and read-data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_rdData <= '0;
        end else begin
            if (w_doWr) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doRd) begin
                r_rdPtr  <= r_rdPtr + 1'b1;
                r_rdData <= r_mem[r_rdPtr[AW-1:0]];
            end
        end
    end

    assign o_rdData = r_rdData;
    assign o_full   = w_full;
    assign o_empty  = w_empty;

endmodule
`default_nettype wire

// File: rtl/adc_frame_builder.sv
`default_nettype none
// ============================================================================
// Module      : adc_frame_builder
// Description : Wraps ADC samples into frames (header, event id, samples,
//               trailer), buffers them in a 32-word FIFO and streams them to
//               a downstream USB FIFO under FifoFull back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_frame_builder
    import adc_frame_builder_pkg::*;
(
    input  logic        Clk,
    input  logic        reset,
    input  logic        StartAcq,
    input  logic        FrameStart,
    input  logic        Hold,
    input  logic [7:0]  SampleNumber,
    input  logic [15:0] Data,
    input  logic        Data_en,
    input  logic        FifoFull,
    output logic [15:0] OutData,
    output logic        OutData_en,
    output logic        Busy,
    output logic [15:0] EventCount
);

    // Hold synchroniser
    logic        r_holdMeta;
    logic        r_holdSync;

    // Frame state
    state_t      r_state;
    logic [7:0]  r_sampleNumber;
    logic [7:0]  r_sampleCount;
    logic        r_overflow;
    logic        r_pendValid;
    logic [15:0] r_pendData;
    logic        r_busy;
    logic [15:0] r_eventCount;
    logic        r_outEn;

    // Datapath decisions
    logic        w_strobe;
    logic [15:0] w_strobeData;
    logic [7:0]  w_countNext;
    logic        w_exitSamples;
    logic        w_keepPend;
    logic        w_fifoWr;
    logic [15:0] w_fifoWrData;
    logic        w_fifoRd;
    logic        w_fifoFull;
    logic        w_fifoEmpty;
    logic [15:0] w_fifoRdData;

    // Two-flop synchroniser for the asynchronous Hold level
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_holdMeta <= 1'b0;
            r_holdSync <= 1'b0;
        end else begin
            r_holdMeta <= Hold;
            r_holdSync <= r_holdMeta;
        end
    end

    // FIFO write word selection and sample-phase exit decision for the current state
    always_comb begin
        w_strobe      = 1'b0;
        w_strobeData  = Data;
        w_countNext   = r_sampleCount;
        w_exitSamples = 1'b0;
        w_keepPend    = 1'b0;
        w_fifoWr      = 1'b0;
        w_fifoWrData  = HEADER_WORD;
        case (r_state)
            ST_HEADER: begin
                w_fifoWr     = !w_fifoFull;
                w_fifoWrData = HEADER_WORD;
            end
            ST_EVENT_ID: begin
                w_fifoWr     = !w_fifoFull;
                w_fifoWrData = r_eventCount;
            end
            ST_SAMPLES: begin
                if (r_sampleCount == r_sampleNumber) begin
                    // Nothing left to collect (zero-length frame)
                    w_exitSamples = 1'b1;
                end else begin
                    // A held strobe goes first; a coincident new strobe waits in the holding slot
                    w_strobe      = r_pendValid || Data_en;
                    w_strobeData  = r_pendValid ? r_pendData : Data;
                    w_keepPend    = r_pendValid && Data_en;
                    if (w_strobe) begin
                        w_countNext = r_sampleCount + 8'd1;
                    end
                    w_fifoWr      = w_strobe && !w_fifoFull;
                    w_fifoWrData  = w_strobeData;
                    w_exitSamples = (w_countNext == r_sampleNumber) ||
                                    (!r_holdSync && !w_keepPend);
                end
            end
            ST_TRAILER: begin
                w_fifoWr     = !w_fifoFull;
                w_fifoWrData = trailerWord(r_overflow, r_sampleCount);
            end
            default: begin
                w_fifoWr = 1'b0;
            end
        endcase
    end

    // Frame sequencing: header, event id, samples, trailer
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_sampleNumber <= 8'd0;
            r_sampleCount  <= 8'd0;
            r_overflow     <= 1'b0;
            r_pendValid    <= 1'b0;
            r_pendData     <= 16'd0;
            r_busy         <= 1'b0;
            r_eventCount   <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (FrameStart && StartAcq) begin
                        r_state        <= ST_HEADER;
                        r_sampleNumber <= SampleNumber;
                        r_sampleCount  <= 8'd0;
                        r_overflow     <= 1'b0;
                        r_pendValid    <= 1'b0;
                        r_busy         <= 1'b1;
                    end
                end
                ST_HEADER: begin
                    if (Data_en) begin
                        r_pendValid <= 1'b1;
                        r_pendData  <= Data;
                    end
                    if (!w_fifoFull) begin
                        r_state <= ST_EVENT_ID;
                    end
                end
                ST_EVENT_ID: begin
                    if (Data_en) begin
                        r_pendValid <= 1'b1;
                        r_pendData  <= Data;
                    end
                    if (!w_fifoFull) begin
                        r_state <= ST_SAMPLES;
                    end
                end
                ST_SAMPLES: begin
                    r_sampleCount <= w_countNext;
                    if (w_strobe && w_fifoFull) begin
                        r_overflow <= 1'b1;
                    end
                    if (r_pendValid && w_strobe) begin
                        r_pendValid <= Data_en;
                        r_pendData  <= Data;
                    end
                    if (w_exitSamples) begin
                        r_state     <= ST_TRAILER;
                        r_pendValid <= 1'b0;
                    end
                end
                ST_TRAILER: begin
                    if (!w_fifoFull) begin
                        r_state      <= ST_IDLE;
                        r_eventCount <= r_eventCount + 16'd1;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Pop whenever data is buffered and downstream can accept it this cycle
    assign w_fifoRd = !w_fifoEmpty && !FifoFull;

    // Output strobe tracks the pop one cycle later, aligned with the FIFO read register
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_outEn <= 1'b0;
        end else begin
            r_outEn <= w_fifoRd;
        end
    end

    frame_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_frame_fifo (
        .clk      (Clk),
        .rst      (reset),
        .i_wrEn   (w_fifoWr),
        .i_wrData (w_fifoWrData),
        .i_rdEn   (w_fifoRd),
        .o_rdData (w_fifoRdData),
        .o_full   (w_fifoFull),
        .o_empty  (w_fifoEmpty)
    );

    assign OutData    = w_fifoRdData;
    assign OutData_en = r_outEn;
    assign Busy       = r_busy;
    assign EventCount = r_eventCount;

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_builder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_adc_frame_builder
// Description : Self-checking bench for adc_frame_builder. Expected output
//               streams are built from the framing rules by a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_frame_builder;

    logic        Clk = 1'b0;
    logic        reset;
    logic        StartAcq;
    logic        FrameStart;
    logic        Hold;
    logic [7:0]  SampleNumber;
    logic [15:0] Data;
    logic        Data_en;
    logic        FifoFull;
    logic [15:0] OutData;
    logic        OutData_en;
    logic        Busy;
    logic [15:0] EventCount;

    int          assertCnt = 0;
    int          failCnt   = 0;
    logic [15:0] gotQ[$];
    logic        busyNowQ[$];
    logic        busyBackQ[$];
    logic [15:0] expQ[$];
    logic [15:0] sampQ[$];
    logic [15:0] modelEvt = 16'd0;
    logic        ffRandom = 1'b0;
    logic        b1 = 1'b0;
    logic        b2 = 1'b0;

    always #5 Clk = ~Clk;

    adc_frame_builder dut (
        .Clk          (Clk),
        .reset        (reset),
        .StartAcq     (StartAcq),
        .FrameStart   (FrameStart),
        .Hold         (Hold),
        .SampleNumber (SampleNumber),
        .Data         (Data),
        .Data_en      (Data_en),
        .FifoFull     (FifoFull),
        .OutData      (OutData),
        .OutData_en   (OutData_en),
        .Busy         (Busy),
        .EventCount   (EventCount)
    );

    // Output monitor: collect every strobed word with Busy now and two cycles back
    always @(negedge Clk) begin
        if (OutData_en === 1'b1) begin
            gotQ.push_back(OutData);
            busyNowQ.push_back(Busy);
            busyBackQ.push_back(b2);
        end
        b2 = b1;
        b1 = Busy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
            if (ffRandom) FifoFull = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assertCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic startFrame(input logic [7:0] n);
        SampleNumber = n;
        FrameStart   = 1'b1;
        tick();
        FrameStart   = 1'b0;
        SampleNumber = 8'($urandom);
    endtask

    task automatic strobe(input logic [15:0] d, input int gap);
        Data    = d;
        Data_en = 1'b1;
        tick();
        Data_en = 1'b0;
        Data    = 16'($urandom);
        tick(gap - 1);
    endtask

    // Reference frame: header, event id, samples that fit in 'cap' buffered words, trailer
    task automatic modelFrame(input int cap);
        logic [15:0] words[$];
        logic        ovf;
        int          cnt;
        ovf = 1'b0;
        cnt = sampQ.size();
        words.push_back(16'hADC5);
        words.push_back(modelEvt);
        foreach (sampQ[i]) begin
            if (words.size() < cap) words.push_back(sampQ[i]);
            else ovf = 1'b1;
        end
        words.push_back({4'hE, ovf, 3'b000, cnt[7:0]});
        foreach (words[i]) expQ.push_back(words[i]);
        sampQ.delete();
        modelEvt = modelEvt + 16'd1;
    endtask

    // Wait for the expected words, then compare the stream word by word
    task automatic drain(input string tag, input bit busyEdge);
        int waited;
        int last;
        waited = 0;
        while ((gotQ.size() < expQ.size() || Busy !== 1'b0) && waited < 2000) begin
            tick();
            waited++;
        end
        tick(3);
        check({tag, " words"}, 16'(gotQ.size()), 16'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            check($sformatf("%s w%0d", tag, i), (i < gotQ.size()) ? gotQ[i] : 16'hxxxx, expQ[i]);
        end
        check({tag, " evtcnt"}, EventCount, modelEvt);
        check({tag, " busy"}, {15'd0, Busy}, 16'd0);
        if (busyEdge && gotQ.size() > 0) begin
            last = gotQ.size() - 1;
            check({tag, " busy at trailer out"}, {15'd0, busyNowQ[last]}, 16'd0);
            check({tag, " busy at trailer write"}, {15'd0, busyBackQ[last]}, 16'd1);
        end
        gotQ.delete();
        busyNowQ.delete();
        busyBackQ.delete();
        expQ.delete();
    endtask

    initial begin
        logic [15:0] d;
        int          n;
        int          gap;

        reset        = 1'b1;
        StartAcq     = 1'b1;
        FrameStart   = 1'b0;
        Hold         = 1'b1;
        SampleNumber = 8'd0;
        Data         = 16'd0;
        Data_en      = 1'b0;
        FifoFull     = 1'b0;
        tick(3);
        check("reset OutData", OutData, 16'd0);
        check("reset OutData_en", {15'd0, OutData_en}, 16'd0);
        check("reset Busy", {15'd0, Busy}, 16'd0);
        check("reset EventCount", EventCount, 16'd0);
        reset = 1'b0;
        tick(4);

        // Four-sample frame
        startFrame(8'd4);
        for (int i = 1; i <= 4; i++) begin
            d = 16'h0100 + 16'(i);
            sampQ.push_back(d);
            strobe(d, 3);
        end
        modelFrame(1000);
        drain("basic", 1'b0);

        // Zero-length frame
        startFrame(8'd0);
        tick(2);
        modelFrame(1000);
        drain("zero", 1'b0);

        // Hold drops after two of eight samples
        startFrame(8'd8);
        for (int i = 0; i < 2; i++) begin
            d = 16'($urandom);
            sampQ.push_back(d);
            strobe(d, 3);
        end
        Hold = 1'b0;
        tick(6);
        modelFrame(1000);
        drain("holdlow", 1'b1);
        Hold = 1'b1;
        tick(4);

        // Downstream full for a whole 40-sample frame
        FifoFull = 1'b1;
        tick();
        startFrame(8'd40);
        for (int i = 0; i < 40; i++) begin
            d = 16'($urandom);
            sampQ.push_back(d);
            strobe(d, 2);
        end
        tick(5);
        check("ffull no output", 16'(gotQ.size()), 16'd0);
        check("ffull trailer stall", {15'd0, Busy}, 16'd1);
        FifoFull = 1'b0;
        modelFrame(32);
        drain("ffull", 1'b0);

        // Strobe right after FrameStart; StartAcq dropped and stray FrameStart mid-frame
        startFrame(8'd3);
        d = 16'($urandom);
        sampQ.push_back(d);
        strobe(d, 3);
        StartAcq = 1'b0;
        d = 16'($urandom);
        sampQ.push_back(d);
        strobe(d, 2);
        StartAcq     = 1'b1;
        SampleNumber = 8'd1;
        FrameStart   = 1'b1;
        tick();
        FrameStart   = 1'b0;
        tick();
        d = 16'($urandom);
        sampQ.push_back(d);
        strobe(d, 3);
        modelFrame(1000);
        drain("early", 1'b0);

        // FrameStart without StartAcq opens nothing
        StartAcq   = 1'b0;
        FrameStart = 1'b1;
        tick();
        FrameStart = 1'b0;
        tick(5);
        check("noacq busy", {15'd0, Busy}, 16'd0);
        check("noacq words", 16'(gotQ.size()), 16'd0);
        StartAcq = 1'b1;

        // Randomised frames with random downstream back-pressure
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 12);
            ffRandom = 1'b1;
            startFrame(8'(n));
            for (int i = 0; i < n; i++) begin
                d   = 16'($urandom);
                gap = $urandom_range(2, 4);
                sampQ.push_back(d);
                strobe(d, gap);
            end
            ffRandom = 1'b0;
            FifoFull = 1'b0;
            modelFrame(1000);
            drain($sformatf("rand%0d", f), 1'b0);
        end

        // Reset in the middle of a frame
        startFrame(8'd6);
        expQ.push_back(16'hADC5);
        expQ.push_back(modelEvt);
        for (int i = 0; i < 3; i++) begin
            d = 16'($urandom);
            expQ.push_back(d);
            strobe(d, 3);
        end
        tick(4);
        #2;
        reset = 1'b1;
        #1;
        check("midreset OutData", OutData, 16'd0);
        check("midreset OutData_en", {15'd0, OutData_en}, 16'd0);
        check("midreset Busy", {15'd0, Busy}, 16'd0);
        check("midreset EventCount", EventCount, 16'd0);
        modelEvt = 16'd0;
        tick(2);
        reset = 1'b0;
        tick(4);
        drain("partial", 1'b0);
        startFrame(8'd2);
        for (int i = 0; i < 2; i++) begin
            d = 16'($urandom);
            sampQ.push_back(d);
            strobe(d, 3);
        end
        modelFrame(1000);
        drain("afterreset", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
`default_nettype wire
